// File: rtl/merge_seq_n.sv
// merge_seq_n: merges two pre-sorted N-key lists into one 2N-key sorted vector, one key per clock.
// Define MERGE_DESCENDING_EN to merge descending-sorted lists (key 0 of c is the largest).
module merge_seq_n #(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             load,
  input  logic [2*N*WIDTH-1:0]   inba,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [2*N*WIDTH-1:0]   c
);

  localparam int PW = $clog2(N + 1);
  localparam int OW = $clog2(2 * N + 1);

  typedef enum logic [1:0] {S_IDLE, S_MERGE, S_FIN} state_t;

  state_t state_q, state_d;

  logic [N-1:0][WIDTH-1:0]   a_q, b_q;
  logic [2*N-1:0][WIDTH-1:0] wbuf_q;
  logic [PW-1:0]             ia_q, ib_q;
  logic [OW-1:0]             o_q;

  logic [WIDTH-1:0] ka, kb;
  logic             a_left, b_left, a_wins, take_a, last;

  // Head-of-list keys; an exhausted pointer selects nothing and is masked by a_left/b_left.
  always_comb begin
    ka = '0;
    kb = '0;
    for (int i = 0; i < N; i++) begin
      if (ia_q == PW'(i)) ka = a_q[i];
      if (ib_q == PW'(i)) kb = b_q[i];
    end
    a_left = (ia_q != PW'(N));
    b_left = (ib_q != PW'(N));
`ifdef MERGE_DESCENDING_EN
    a_wins = (ka >= kb);
`else
    a_wins = (ka <= kb);
`endif
    take_a = !b_left || (a_left && a_wins);
    last   = (o_q == OW'(2 * N - 1));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_MERGE;
      S_MERGE: if (last)  state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  assign busy = (state_q != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      wbuf_q <= '0;
      ia_q   <= '0;
      ib_q   <= '0;
      o_q    <= '0;
      c      <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (load[0]) a_q <= inba[N*WIDTH-1:0];
          if (load[1]) b_q <= inba[2*N*WIDTH-1:N*WIDTH];
          if (start) begin
            ia_q <= '0;
            ib_q <= '0;
            o_q  <= '0;
          end
        end
        S_MERGE: begin
          for (int k = 0; k < 2 * N; k++)
            if (o_q == OW'(k)) wbuf_q[k] <= take_a ? ka : kb;
          if (take_a) ia_q <= ia_q + PW'(1);
          else        ib_q <= ib_q + PW'(1);
          o_q <= o_q + OW'(1);
        end
        S_FIN: begin
          // Result is published atomically; c never shows a partial merge.
          c    <= wbuf_q;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_merge_seq_n.sv
// Directed bench for merge_seq_n (N=4, WIDTH=8) plus a random N=8, WIDTH=16 instance vs a sort model.
module tb_merge_seq_n;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int W2 = 16;
  localparam int N2 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic [1:0]         load;
  logic [2*N*W-1:0]   inba;
  logic               start, busy, done;
  logic [2*N*W-1:0]   c;

  logic [1:0]         load2;
  logic [2*N2*W2-1:0] inba2;
  logic               start2, busy2, done2;
  logic [2*N2*W2-1:0] c2;

  merge_seq_n #(.WIDTH(W), .N(N)) dut (
    .clk(clk), .rst(rst), .load(load), .inba(inba), .start(start),
    .busy(busy), .done(done), .c(c)
  );

  merge_seq_n #(.WIDTH(W2), .N(N2)) dut2 (
    .clk(clk), .rst(rst), .load(load2), .inba(inba2), .start(start2),
    .busy(busy2), .done(done2), .c(c2)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [63:0] exp_c;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] p4(input logic [7:0] k0, k1, k2, k3);
    return {k3, k2, k1, k0};
  endfunction

  function automatic logic [63:0] p8(input logic [7:0] k0, k1, k2, k3, k4, k5, k6, k7);
    return {k7, k6, k5, k4, k3, k2, k1, k0};
  endfunction

  task automatic load_ab(input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk); load = 2'b01; inba = {32'hdeadbeef, av};
    @(negedge clk); load = 2'b10; inba = {bv, 32'h5a5a5a5a};
    @(negedge clk); load = 2'b00;
  endtask

  // Start a merge (optionally with same-edge loads) and follow it to the done pulse.
  task automatic run(input string tag, input logic [63:0] exp, input bit disturb,
                     input logic [1:0] ld, input logic [63:0] data);
    int cyc;
    bit bok, cok;
    @(negedge clk); start = 1'b1; load = ld; inba = data;
    @(negedge clk); start = 1'b0; load = 2'b00;
    cyc = 0; bok = 1'b1; cok = 1'b1;
    while (!done && cyc < 30) begin
      if (!busy) bok = 1'b0;
      if (c !== exp_c) cok = 1'b0;
      if (disturb && cyc == 2) begin start = 1'b1; load = 2'b11; inba = 64'hffee_ddcc_bbaa_9988; end
      if (disturb && cyc == 3) begin start = 1'b0; load = 2'b00; end
      @(negedge clk); cyc++;
    end
    check({tag, "_latency"}, 256'(cyc), 256'(9));
    check({tag, "_busy_during"}, 256'(bok), 256'(1));
    check({tag, "_c_held"}, 256'(cok), 256'(1));
    check({tag, "_busy_at_done"}, 256'(busy), 256'(0));
    check({tag, "_c"}, 256'(c), 256'(exp));
    exp_c = exp;
    @(negedge clk);
    check({tag, "_done_pulse"}, 256'(done), 256'(0));
    check({tag, "_idle_after"}, 256'(busy), 256'(0));
  endtask

  typedef logic [15:0] arr_t [16];

  function automatic arr_t sortn(input arr_t x, input int n);
    arr_t y = x;
    logic [15:0] t;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n - 1 - i; j++)
`ifdef MERGE_DESCENDING_EN
        if (y[j] < y[j+1]) begin t = y[j]; y[j] = y[j+1]; y[j+1] = t; end
`else
        if (y[j] > y[j+1]) begin t = y[j]; y[j] = y[j+1]; y[j+1] = t; end
`endif
    return y;
  endfunction

  logic [31:0] va1, vb1, va2, vb2, va3, vb3;
  logic [63:0] ve1, ve2, ve3;

  initial begin
`ifdef MERGE_DESCENDING_EN
    va1 = p4(8'd201, 8'd200, 8'd0, 8'd0);   vb1 = p4(8'd23, 8'd9, 8'd1, 8'd1);
    ve1 = p8(8'd201, 8'd200, 8'd23, 8'd9, 8'd1, 8'd1, 8'd0, 8'd0);
    va2 = p4(8'd255, 8'd255, 8'd5, 8'd5);   vb2 = p4(8'd255, 8'd5, 8'd5, 8'd0);
    ve2 = p8(8'd255, 8'd255, 8'd255, 8'd5, 8'd5, 8'd5, 8'd5, 8'd0);
    va3 = p4(8'd40, 8'd30, 8'd20, 8'd10);   vb3 = p4(8'd4, 8'd3, 8'd2, 8'd1);
    ve3 = p8(8'd40, 8'd30, 8'd20, 8'd10, 8'd4, 8'd3, 8'd2, 8'd1);
`else
    va1 = p4(8'd0, 8'd0, 8'd200, 8'd201);   vb1 = p4(8'd1, 8'd1, 8'd9, 8'd23);
    ve1 = p8(8'd0, 8'd0, 8'd1, 8'd1, 8'd9, 8'd23, 8'd200, 8'd201);
    va2 = p4(8'd5, 8'd5, 8'd255, 8'd255);   vb2 = p4(8'd0, 8'd5, 8'd5, 8'd255);
    ve2 = p8(8'd0, 8'd5, 8'd5, 8'd5, 8'd5, 8'd255, 8'd255, 8'd255);
    va3 = p4(8'd1, 8'd2, 8'd3, 8'd4);       vb3 = p4(8'd10, 8'd20, 8'd30, 8'd40);
    ve3 = p8(8'd1, 8'd2, 8'd3, 8'd4, 8'd10, 8'd20, 8'd30, 8'd40);
`endif
    rst = 1'b1; load = '0; inba = '0; start = 1'b0;
    load2 = '0; inba2 = '0; start2 = 1'b0;
    exp_c = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_done", 256'(done), 256'(0));
    check("rst_c", 256'(c), 256'(0));
    check("rst_c2", 256'(c2), 256'(0));
    rst = 1'b0;

    load_ab(va1, vb1); run("basic", ve1, 1'b0, 2'b00, 64'h0);
    load_ab(va2, vb2); run("ties", ve2, 1'b0, 2'b00, 64'h0);
    load_ab(va3, vb3); run("exhaust", ve3, 1'b0, 2'b00, 64'h0);
    load_ab(vb3, va3); run("exhaust_swap", ve3, 1'b0, 2'b00, 64'h0);

    // Start/load while busy must be ignored: the rerun without reloading proves A/B were untouched.
    load_ab(va1, vb1); run("protocol", ve1, 1'b1, 2'b00, 64'h0);
    run("protocol_rerun", ve1, 1'b0, 2'b00, 64'h0);
    run("load_with_start", ve2, 1'b0, 2'b11, {vb2, va2});

    begin
      bit saw_done;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1; #1;
      check("midrst_c", 256'(c), 256'(0));
      check("midrst_busy", 256'(busy), 256'(0));
      check("midrst_done", 256'(done), 256'(0));
      @(negedge clk); rst = 1'b0;
      exp_c = '0;
      saw_done = 1'b0;
      repeat (12) begin @(negedge clk); if (done || busy) saw_done = 1'b1; end
      check("midrst_no_done", 256'(saw_done), 256'(0));
      load_ab(va1, vb1); run("after_rst", ve1, 1'b0, 2'b00, 64'h0);
    end

    for (int t = 0; t < 4; t++) begin
      arr_t ra, rb, all, ref_s;
      logic [2*N2*W2-1:0] expw;
      int cyc;
      for (int i = 0; i < 16; i++) begin
        ra[i] = (t == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom_range(0, 65535));
        rb[i] = (t == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom_range(0, 65535));
      end
      if (t == 3) begin ra[0] = 16'hffff; rb[0] = 16'h0000; end
      ra = sortn(ra, N2);
      rb = sortn(rb, N2);
      for (int i = 0; i < N2; i++) begin
        all[i] = ra[i]; all[N2+i] = rb[i];
        inba2[i*W2 +: W2]      = ra[i];
        inba2[(N2+i)*W2 +: W2] = rb[i];
      end
      ref_s = sortn(all, 2 * N2);
      for (int k = 0; k < 2 * N2; k++) expw[k*W2 +: W2] = ref_s[k];
      @(negedge clk); load2 = 2'b11; start2 = 1'b1;
      @(negedge clk); load2 = 2'b00; start2 = 1'b0;
      cyc = 0;
      while (!done2 && cyc < 60) begin @(negedge clk); cyc++; end
      check($sformatf("rand%0d_latency", t), 256'(cyc), 256'(2 * N2 + 1));
      check($sformatf("rand%0d_c", t), 256'(c2), 256'(expw));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
